simple_circuit_scan_ctrl: RTL and testbench
===========================================

# simple_circuit_scan_ctrl

Self-test sequencer for the three-input/four-output `simple_circuit` gate netlist. On `start` it drives all 8 input vectors onto the circuit under test and waits a settle time per vector. It samples the four outputs, compares them against a golden truth table, and reports pass/fail, a mismatch count, a per-vector fail map and the first failing vector. It sits beside the netlist as the trojan-detection stimulus/response controller.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range ≥1, a value of 0 is a compile-time error.
- `CNT_W`, default 4: width of the mismatch counter; must be ≥4.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled only in IDLE.
- `abort`  in  1  cancels a run in progress.
- `dut_a`, `dut_b`, `dut_c`  out  1 each  registered stimulus to the circuit.
- `dut_e`, `dut_f`, `dut_g`, `dut_h`  in  1 each  circuit responses.
- `busy`  out  1  high from first APPLY cycle through last SAMPLE cycle.
- `done`  out  1  one-cycle pulse at run completion.
- `pass`  out  1  1 when the completed run had zero mismatches.
- `mismatch_cnt`  out  CNT_W  number of failing vectors, saturating.
- `fail_map`  out  8  bit v set when vector v mismatched.
- `first_fail_vec`  out  3  index of the lowest failing vector.
- `first_fail_valid`  out  1  1 when `first_fail_vec` is meaningful.
- `signature`  out  4  MISR signature (see Configuration).

## Operation
- The vector index is v = {A,B,C}, with A as MSB. Vectors are applied in order 0..7.
- Golden response {E,F,G,H} per v, 0..7: 0010, 0100, 0010, 0100, 0110, 0100, 1110, 1101.
- FSM states are IDLE, APPLY, SAMPLE and DONE.
- IDLE→APPLY on `start`=1 and `abort`=0. Taking this transition clears all results and sets v=0.
- APPLY: hold `dut_*` = v for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE, one cycle, vector still driven:
  - Compare the inputs to the golden response for v.
  - On mismatch: set `fail_map[v]` and increment `mismatch_cnt`, saturating at 2^CNT_W−1.
  - If `first_fail_valid`=0 on a mismatch, load `first_fail_vec`=v and set `first_fail_valid`=1.
  - If v<7, increment v and go to APPLY. Otherwise go to DONE.
- DONE, one cycle: `done`=1, `pass`=(count==0), `dut_*`=0. Then go to IDLE.
- Results hold stable from DONE until the next accepted `start`.
- `abort` in APPLY or SAMPLE: go to IDLE next cycle with `dut_*`=0. No `done` pulse. `pass`=0. Partial `fail_map`, `mismatch_cnt` and `first_fail_*` are retained.
- `start` while not in IDLE is ignored.
- `start` and `abort` together in IDLE: abort wins and no run begins.
- Reset values: all outputs 0 and state IDLE. Reset mid-run takes effect immediately, with no done.

## Timing
- `start` sampled high at edge k: `busy` and vector 0 appear after edge k.
- Each vector occupies SETTLE_CYCLES+1 cycles.
- `done` is high in the cycle after edge k+8·(SETTLE_CYCLES+1). With the default this is 24 edges after k.
- `busy` is low in the DONE cycle. A new `start` is accepted in the following IDLE cycle.
- The `dut_*` inputs are combinational into the compare in SAMPLE. The circuit must settle within SETTLE_CYCLES cycles.

## Configuration
- `SIMPLE_SCAN_MISR_EN` defined:
  - A 4-bit MISR (x^4+x+1, seed 0) updates in each SAMPLE: sig ← ({sig[2:0],0} ⊕ (sig[3] ? 0011 : 0000)) ⊕ {E,F,G,H}.
  - The MISR clears on accepted `start`. `signature` holds the result from DONE onward.
  - Fault-free result is 4'h4.
- Macro undefined: `signature` is tied to 0 and no MISR logic is built.

## Structure
- Package `simple_scan_pkg` holds:
  - the FSM state enum;
  - `NUM_VEC`=8;
  - the golden response table, 8×4;
  - the MISR tap constant 4'b0011;
  - `GOLDEN_SIG`=4'h4.
- One sub-module, `simple_scan_misr`, containing the signature register with clear/enable. It is instantiated only under the macro.

## Test plan
- Fault-free netlist, SETTLE_CYCLES=2, `start` pulse → `done` 24 edges later; `pass`=1, `mismatch_cnt`=0, `fail_map`=8'h00, `first_fail_valid`=0; with macro, `signature`=4'h4.
- H stuck-at-1 → `pass`=0, `mismatch_cnt`=7, `fail_map`=8'h7F, `first_fail_vec`=0.
- Trojan inverting H only when ABC=101 → `mismatch_cnt`=1, `fail_map`=8'h20, `first_fail_vec`=5; with macro, `signature`≠4'h4.
- `abort` during APPLY of vector 3 → `busy`=0 and `dut_*`=0 next cycle, no `done`, `pass`=0; a new `start` then runs a full clean pass.
- `start` held high during the run and again in DONE → exactly one run per accepted start; `start`+`abort` together in IDLE → stays IDLE.
- `rst_n` asserted mid-run at vector 4 → all outputs 0 immediately, state IDLE; the next run completes normally.

Source files
------------

// File: rtl/simple_scan_pkg.sv
// simple_scan_pkg: shared types and constants for the simple_circuit scan controller
//   FSM state enum, vector count, golden {E,F,G,H} response table, MISR taps and
//   the fault-free MISR signature.
package simple_scan_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   localparam int NUM_VEC = 8;

   // Golden {E,F,G,H} per vector, vector 0 in the least significant nibble.
   localparam logic [4*NUM_VEC-1:0] GOLDEN_TBL = 32'hDE46_4242;

   localparam logic [3:0] MISR_TAPS  = 4'b0011;
   localparam logic [3:0] GOLDEN_SIG = 4'h4;

   function automatic logic [3:0] golden(input logic [2:0] v);
      return GOLDEN_TBL[{v, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/simple_scan_misr.sv
// simple_scan_misr: 4-bit MISR (x^4+x+1, seed 0) compacting sampled responses
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear back to the seed
//   en         : fold din into the signature this cycle
//   din[3:0]   : response word {E,F,G,H}
//   sig[3:0]   : current signature
module simple_scan_misr
   import simple_scan_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [3:0] din,
   output logic [3:0] sig
);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         sig <= '0;
      else if (clr)
         sig <= '0;
      else if (en)
         sig <= {sig[2:0], 1'b0} ^ (sig[3] ? MISR_TAPS : 4'b0000) ^ din;

endmodule

// File: rtl/simple_circuit_scan_ctrl.sv
// simple_circuit_scan_ctrl: self-test sequencer for the simple_circuit netlist
//   Applies vectors 0..7 as {A,B,C}, samples {E,F,G,H} after SETTLE_CYCLES and
//   compares against the golden table.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, abort               : run request (IDLE only) / cancel a run
//   dut_a, dut_b, dut_c        : registered stimulus to the circuit
//   dut_e, dut_f, dut_g, dut_h : circuit responses
//   busy, done, pass           : run status
//   mismatch_cnt, fail_map     : saturating failure count, per-vector fail bits
//   first_fail_vec/_valid      : lowest failing vector
//   signature                  : MISR result when SIMPLE_SCAN_MISR_EN is defined, else 0
module simple_circuit_scan_ctrl
   import simple_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             dut_a,
   output logic             dut_b,
   output logic             dut_c,
   input  logic             dut_e,
   input  logic             dut_f,
   input  logic             dut_g,
   input  logic             dut_h,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [7:0]       fail_map,
   output logic [2:0]       first_fail_vec,
   output logic             first_fail_valid,
   output logic [3:0]       signature
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   generate
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("SETTLE_CYCLES must be at least 1");
      end
      if (CNT_W < 4) begin : g_bad_cnt
         $error("CNT_W must be at least 4");
      end
   endgenerate

   state_t           state, state_nxt;
   logic [SW-1:0]    settle;
   logic [2:0]       vec;
   logic [3:0]       resp;
   logic             go, smp, miss, settled;
   logic [CNT_W-1:0] cnt_nxt;

   assign resp    = {dut_e, dut_f, dut_g, dut_h};
   assign go      = state == IDLE && start && !abort;
   // An abort in SAMPLE wins over the compare, so nothing is recorded that cycle.
   assign smp     = state == SAMPLE && !abort;
   assign miss    = smp && resp != golden(vec);
   assign settled = settle == SW'(SETTLE_CYCLES - 1);
   assign cnt_nxt = (miss && !(&mismatch_cnt)) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;

   assign busy  = state == APPLY || state == SAMPLE;
   assign done  = state == DONE;
   assign dut_a = vec[2];
   assign dut_b = vec[1];
   assign dut_c = vec[0];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = go ? APPLY : IDLE;
         APPLY:   state_nxt = abort ? IDLE : settled ? SAMPLE : APPLY;
         SAMPLE:  state_nxt = abort ? IDLE : (vec == 3'd7) ? DONE : APPLY;
         default: state_nxt = IDLE;
      endcase
   end

   // vec wraps 7 -> 0 on the last sample, so the stimulus is already 0 in DONE.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         settle           <= '0;
         vec              <= '0;
         pass             <= 1'b0;
         mismatch_cnt     <= '0;
         fail_map         <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         settle <= (state == APPLY && !settled) ? settle + SW'(1) : '0;
         vec    <= (busy && abort) ? 3'd0 : smp ? vec + 3'd1 : vec;
         pass   <= go ? 1'b0 : (smp && vec == 3'd7) ? (cnt_nxt == '0) : pass;
         if (go) begin
            mismatch_cnt     <= '0;
            fail_map         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
         end else if (miss) begin
            mismatch_cnt   <= cnt_nxt;
            fail_map[vec]  <= 1'b1;
            if (!first_fail_valid) begin
               first_fail_vec   <= vec;
               first_fail_valid <= 1'b1;
            end
         end
      end

`ifdef SIMPLE_SCAN_MISR_EN
   simple_scan_misr u_misr (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (go),
      .en   (smp),
      .din  (resp),
      .sig  (signature)
   );
`else
   assign signature = 4'h0;
`endif

endmodule

// File: tb/tb_simple_circuit_scan_ctrl.sv
// tb_simple_circuit_scan_ctrl: scoreboard bench for simple_circuit_scan_ctrl
module tb_simple_circuit_scan_ctrl;

   localparam logic [3:0] GOLD [8] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100,
                                       4'b0110, 4'b0100, 4'b1110, 4'b1101};

   typedef struct {
      logic       pass;
      logic [3:0] cnt;
      logic [7:0] map;
      logic [2:0] ffv;
      logic       ffval;
      logic [3:0] sig;
   } exp_t;

   logic       clk, rst_n, start, abort;
   logic       dut_a, dut_b, dut_c, dut_e, dut_f, dut_g, dut_h;
   logic       busy, done, pass, first_fail_valid;
   logic [3:0] mismatch_cnt, signature;
   logic [7:0] fail_map;
   logic [2:0] first_fail_vec;
   int         fault;
   int         n_tests, n_fail, n_done;
   exp_t       sb [$];

   simple_circuit_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c),
      .dut_e(dut_e), .dut_f(dut_f), .dut_g(dut_g), .dut_h(dut_h),
      .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
      .fail_map(fail_map), .first_fail_vec(first_fail_vec),
      .first_fail_valid(first_fail_valid), .signature(signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0: fault-free, 1: H stuck-at-1, 2: trojan inverting H at ABC=101
   function automatic logic [3:0] resp_of(input logic [2:0] v, input int f);
      logic [3:0] r;
      r = GOLD[v];
      if (f == 1) r[0] = 1'b1;
      if (f == 2 && v == 3'd5) r[0] = ~r[0];
      return r;
   endfunction

   always_comb {dut_e, dut_f, dut_g, dut_h} = resp_of({dut_a, dut_b, dut_c}, fault);

   always @(negedge clk) if (done) n_done++;

   function automatic exp_t model(input int f);
      exp_t e;
      logic [3:0] r, s;
      e = '{1'b0, 4'd0, 8'd0, 3'd0, 1'b0, 4'd0};
      s = 4'd0;
      for (int v = 0; v < 8; v++) begin
         r = resp_of(3'(v), f);
         s = {s[2:0], 1'b0} ^ {2'b00, s[3], s[3]} ^ r;
         if (r != GOLD[v]) begin
            e.map[v] = 1'b1;
            e.cnt++;
            if (!e.ffval) begin
               e.ffv   = 3'(v);
               e.ffval = 1'b1;
            end
         end
      end
      e.pass = e.cnt == 0;
`ifdef SIMPLE_SCAN_MISR_EN
      e.sig = s;
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input int f, input bit hold);
      exp_t e;
      int   n;
      fault = f;
      sb.push_back(model(f));
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      check("busy_on", 32'(busy), 1);
      check("vec0", 32'({dut_a, dut_b, dut_c}), 0);
      n = 1;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("latency", n, 25);
      check("busy_in_done", 32'(busy), 0);
      check("dut_in_done", 32'({dut_a, dut_b, dut_c}), 0);
      e = sb.pop_front();
      check("pass", 32'(pass), 32'(e.pass));
      check("cnt", 32'(mismatch_cnt), 32'(e.cnt));
      check("map", 32'(fail_map), 32'(e.map));
      check("ffvalid", 32'(first_fail_valid), 32'(e.ffval));
      if (e.ffval) check("ffv", 32'(first_fail_vec), 32'(e.ffv));
      check("sig", 32'(signature), 32'(e.sig));
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("hold_results", 32'(fail_map), 32'(e.map));
   endtask

   task automatic wait_vec(input logic [2:0] v);
      int n;
      n = 0;
      while ({dut_a, dut_b, dut_c} != v && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("reach_vec", 32'({dut_a, dut_b, dut_c}), 32'(v));
   endtask

   initial begin
      int nd;
      n_tests = 0; n_fail = 0; n_done = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; fault = 0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_cnt", 32'(mismatch_cnt), 0);
      check("rst_map", 32'(fail_map), 0);
      check("rst_ffvalid", 32'(first_fail_valid), 0);
      check("rst_ffv", 32'(first_fail_vec), 0);
      check("rst_sig", 32'(signature), 0);
      check("rst_dut", 32'({dut_a, dut_b, dut_c}), 0);
      rst_n = 1'b1;
      @(negedge clk);
`ifdef SIMPLE_SCAN_MISR_EN
      check("golden_sig_model", 32'(model(0).sig), 32'h4);
`endif
      run(0, 1'b0);
      run(1, 1'b0);
      run(2, 1'b0);
      nd = n_done;
      run(0, 1'b1);
      repeat (30) @(negedge clk);
      check("hold_one_run", n_done - nd, 1);
      check("hold_idle", 32'(busy), 0);
      start = 1'b1; abort = 1'b1;
      repeat (5) @(negedge clk);
      check("start_abort_busy", 32'(busy), 0);
      check("start_abort_dut", 32'({dut_a, dut_b, dut_c}), 0);
      check("start_abort_keep", 32'(pass), 1);
      start = 1'b0; abort = 1'b0;
      fault = 1;
      nd = n_done;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_vec(3'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_dut", 32'({dut_a, dut_b, dut_c}), 0);
      check("abort_pass", 32'(pass), 0);
      check("abort_cnt", 32'(mismatch_cnt), 3);
      check("abort_map", 32'(fail_map), 32'h07);
      check("abort_ffvalid", 32'(first_fail_valid), 1);
      check("abort_ffv", 32'(first_fail_vec), 0);
      repeat (30) @(negedge clk);
      check("abort_no_done", n_done - nd, 0);
      run(0, 1'b0);
      fault = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_vec(3'd4);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_busy", 32'(busy), 0);
      check("mrst_dut", 32'({dut_a, dut_b, dut_c}), 0);
      check("mrst_cnt", 32'(mismatch_cnt), 0);
      check("mrst_map", 32'(fail_map), 0);
      check("mrst_ffvalid", 32'(first_fail_valid), 0);
      check("mrst_done", 32'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(0, 1'b0);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
